// File: rtl/sma_window_engine.sv
// -----------------------------------------------------------------------------
// sma_window_engine
//
// Purpose:
//   Keeps a sliding window of the last BUFFER_SIZE prices for each of
//   NUM_STOCKS independent stocks. Each window has its own write pointer,
//   sample count and running sum. An update takes three cycles:
//     IDLE   - accept a request
//     READ   - registered read of the slot about to be overwritten
//     UPDATE - write the new price and update the running sum
//   The sum is kept incrementally: sum - evicted + incoming.
//
// Configuration:
//   SMA_MEAN_EN - when defined, adds output o_mean. It equals
//                 o_sum >> $clog2(BUFFER_SIZE) while the window is full,
//                 and 0 otherwise.
//
// Ports:
//   i_clk            sole clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_valid          price update request
//   o_ready          high in IDLE only; request accepted on i_valid && o_ready
//   i_stock_id       target stock of the request
//   i_price          incoming price (unsigned)
//   i_clear          with i_valid: clear the stock's window instead
//   o_valid          one-cycle result strobe
//   o_stock_id       stock of the current result
//   o_incoming_price price just written
//   o_outgoing_price price evicted (0 if the window was not full)
//   o_sum            window sum after the update
//   o_count          valid samples in the window after the update
//   o_mean           (SMA_MEAN_EN only) window mean when full, else 0
//   o_full           o_count == BUFFER_SIZE
// -----------------------------------------------------------------------------
module sma_window_engine #(
  parameter  int NUM_STOCKS  = 4,
  parameter  int BUFFER_SIZE = 64,
  parameter  int DATA_WIDTH  = 32,
  localparam int PTR_WIDTH   = $clog2(BUFFER_SIZE),
  localparam int CNT_WIDTH   = PTR_WIDTH + 1,
  localparam int SUM_WIDTH   = DATA_WIDTH + PTR_WIDTH,
  localparam int ID_WIDTH    = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ID_WIDTH-1:0]   i_stock_id,
  input  logic [DATA_WIDTH-1:0] i_price,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic [ID_WIDTH-1:0]   o_stock_id,
  output logic [DATA_WIDTH-1:0] o_incoming_price,
  output logic [DATA_WIDTH-1:0] o_outgoing_price,
  output logic [SUM_WIDTH-1:0]  o_sum,
  output logic [CNT_WIDTH-1:0]  o_count,
`ifdef SMA_MEAN_EN
  output logic [DATA_WIDTH-1:0] o_mean,
`endif
  output logic                  o_full
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_UPDATE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BUFFER_SIZE);

  state_e state_q, state_d;

  // Request fields captured at acceptance; i_* may change afterwards.
  logic [ID_WIDTH-1:0]   req_id_q;
  logic [DATA_WIDTH-1:0] req_price_q;
  logic                  req_clear_q;

  // Per-stock window bookkeeping.
  logic [PTR_WIDTH-1:0]  wptr_q [NUM_STOCKS];
  logic [CNT_WIDTH-1:0]  cnt_q  [NUM_STOCKS];
  logic [SUM_WIDTH-1:0]  sum_q  [NUM_STOCKS];

  // Price storage and its read register.
  logic [DATA_WIDTH-1:0] mem_q  [NUM_STOCKS][BUFFER_SIZE];
  logic [DATA_WIDTH-1:0] rd_q;

  // Registered result outputs.
  logic                  valid_q;
  logic [ID_WIDTH-1:0]   stock_id_q;
  logic [DATA_WIDTH-1:0] in_price_q;
  logic [DATA_WIDTH-1:0] out_price_q;
  logic [SUM_WIDTH-1:0]  res_sum_q;
  logic [CNT_WIDTH-1:0]  res_cnt_q;
  logic                  full_q;

  // Update datapath.
  logic                  accept;
  logic                  in_range;
  logic [ID_WIDTH-1:0]   sid;
  logic [PTR_WIDTH-1:0]  cur_wptr;
  logic [CNT_WIDTH-1:0]  cur_cnt;
  logic [SUM_WIDTH-1:0]  cur_sum;
  logic                  was_full;
  logic [DATA_WIDTH-1:0] outgoing;
  logic [SUM_WIDTH-1:0]  sum_upd;
  logic [CNT_WIDTH-1:0]  cnt_upd;
  logic [PTR_WIDTH-1:0]  wptr_upd;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] res_in_d;
  logic [DATA_WIDTH-1:0] res_out_d;
  logic [SUM_WIDTH-1:0]  res_sum_d;
  logic [CNT_WIDTH-1:0]  res_cnt_d;

  assign o_ready = (state_q == ST_IDLE);
  assign accept  = i_valid && o_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_valid) state_d = ST_READ;
      ST_READ:   state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window update datapath. Out-of-range ids are steered to stock 0 for the
  // array lookups only; in_range gates every state change they could cause.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_range = int'(req_id_q) < NUM_STOCKS;
    sid      = in_range ? req_id_q : '0;
    cur_wptr = wptr_q[sid];
    cur_cnt  = cnt_q[sid];
    cur_sum  = sum_q[sid];

    // A slot only holds a live sample once the window has wrapped, so stale
    // memory is never evicted while count < BUFFER_SIZE.
    was_full = (cur_cnt == FULL_CNT);
    outgoing = was_full ? rd_q : '0;
    sum_upd  = cur_sum - SUM_WIDTH'(outgoing) + SUM_WIDTH'(req_price_q);
    cnt_upd  = was_full ? cur_cnt : cur_cnt + CNT_WIDTH'(1);
    wptr_upd = cur_wptr + PTR_WIDTH'(1);  // wraps naturally at BUFFER_SIZE

    mem_we   = i_rst_n && (state_q == ST_UPDATE) && in_range && !req_clear_q;

    // Clear and out-of-range requests report an all-zero result.
    res_in_d  = '0;
    res_out_d = '0;
    res_sum_d = '0;
    res_cnt_d = '0;
    if (in_range && !req_clear_q) begin
      res_in_d  = req_price_q;
      res_out_d = outgoing;
      res_sum_d = sum_upd;
      res_cnt_d = cnt_upd;
    end
  end

  // ---------------------------------------------------------------------------
  // Control, bookkeeping and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      req_id_q    <= '0;
      req_price_q <= '0;
      req_clear_q <= 1'b0;
      valid_q     <= 1'b0;
      stock_id_q  <= '0;
      in_price_q  <= '0;
      out_price_q <= '0;
      res_sum_q   <= '0;
      res_cnt_q   <= '0;
      full_q      <= 1'b0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        wptr_q[s] <= '0;
        cnt_q[s]  <= '0;
        sum_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;

      if (accept) begin
        req_id_q    <= i_stock_id;
        req_price_q <= i_price;
        req_clear_q <= i_clear;
      end

      if (state_q == ST_UPDATE) begin
        valid_q     <= 1'b1;
        stock_id_q  <= req_id_q;
        in_price_q  <= res_in_d;
        out_price_q <= res_out_d;
        res_sum_q   <= res_sum_d;
        res_cnt_q   <= res_cnt_d;
        full_q      <= (res_cnt_d == FULL_CNT);
        if (in_range) begin
          if (req_clear_q) begin
            wptr_q[sid] <= '0;
            cnt_q[sid]  <= '0;
            sum_q[sid]  <= '0;
          end else begin
            wptr_q[sid] <= wptr_upd;
            cnt_q[sid]  <= cnt_upd;
            sum_q[sid]  <= sum_upd;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Price storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; a zero count already guarantees
  // that stale entries are never evicted into the sum. The write is gated
  // by i_rst_n so a reset during UPDATE abandons the request.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_READ) begin
      rd_q <= mem_q[sid][cur_wptr];
    end
    if (mem_we) begin
      mem_q[sid][cur_wptr] <= req_price_q;
    end
  end

`ifdef SMA_MEAN_EN
  logic [DATA_WIDTH-1:0] mean_q;
  logic [DATA_WIDTH-1:0] res_mean_d;

  always_comb begin
    res_mean_d = '0;
    if (res_cnt_d == FULL_CNT) begin
      res_mean_d = DATA_WIDTH'(res_sum_d >> PTR_WIDTH);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mean_q <= '0;
    end else if (state_q == ST_UPDATE) begin
      mean_q <= res_mean_d;
    end
  end

  assign o_mean = mean_q;
`endif

  assign o_valid          = valid_q;
  assign o_stock_id       = stock_id_q;
  assign o_incoming_price = in_price_q;
  assign o_outgoing_price = out_price_q;
  assign o_sum            = res_sum_q;
  assign o_count          = res_cnt_q;
  assign o_full           = full_q;

endmodule

// File: doc/sma_window_engine.md
SMA_WINDOW_ENGINE -- requirements
Module: sma_window_engine

Interface
REQ-001 Parameter NUM_STOCKS, default 4: number of independent price windows.
REQ-002 Parameter BUFFER_SIZE, default 64: window depth per stock; power of two, >= 2.
REQ-003 Parameter DATA_WIDTH, default 32: unsigned price width.
REQ-004 Derived SUM_WIDTH = DATA_WIDTH + $clog2(BUFFER_SIZE); ID_WIDTH = max(1, $clog2(NUM_STOCKS)).
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_rst_n  in  1  reset, synchronous, active-low.
REQ-007 i_valid  in  1  price update request.
REQ-008 o_ready  out  1  block can accept a request this cycle.
REQ-009 i_stock_id  in  ID_WIDTH  target stock for the request.
REQ-010 i_price  in  DATA_WIDTH  incoming price.
REQ-011 i_clear  in  1  with i_valid: clear the stock's window instead of writing a price.
REQ-012 o_valid  out  1  one-cycle result strobe.
REQ-013 o_stock_id  out  ID_WIDTH  stock of current result.
REQ-014 o_incoming_price  out  DATA_WIDTH  price just written.
REQ-015 o_outgoing_price  out  DATA_WIDTH  price evicted (0 if window not full).
REQ-016 o_sum  out  SUM_WIDTH  window sum after the update.
REQ-017 o_count  out  $clog2(BUFFER_SIZE)+1  valid samples in window after update.
REQ-018 o_full  out  1  o_count == BUFFER_SIZE.

Function
REQ-019 Storage: NUM_STOCKS*BUFFER_SIZE entries; per stock a write pointer, count and running sum.
REQ-020 FSM states IDLE, READ, UPDATE; reset enters IDLE.
REQ-021 o_ready = 1 only in IDLE; a request is accepted when i_valid && o_ready at a rising edge; IDLE -> READ.
REQ-022 READ: registered read of entry [stock][wptr]; request fields latched at acceptance; READ -> UPDATE unconditionally.
REQ-023 UPDATE: write i_price to [stock][wptr]; outgoing = read value if count == BUFFER_SIZE else 0; sum <= sum - outgoing + incoming; count saturates at BUFFER_SIZE; wptr wraps BUFFER_SIZE-1 -> 0; UPDATE -> IDLE.
REQ-024 Latency: o_valid high for exactly one cycle, the second cycle after the acceptance edge; throughput one request per 3 cycles.
REQ-025 All result outputs are registered and hold value until the next o_valid.
REQ-026 Requests for different stocks never affect each other's pointer, count or sum.
REQ-027 Clear request: stock's wptr, count, sum set to 0 in UPDATE; memory not written; o_valid pulses with o_sum=0, o_count=0, o_outgoing_price=0, o_incoming_price=0.
REQ-028 i_stock_id >= NUM_STOCKS: request accepted, no state changes, o_valid still pulses with o_sum=0, o_count=0.
REQ-029 i_valid while o_ready=0 is ignored; no queuing.
REQ-030 Sum arithmetic is unsigned and never overflows given SUM_WIDTH.

Reset
REQ-031 While i_rst_n=0 at an edge: FSM -> IDLE, all wptr/count/sum -> 0, o_valid=0, all other outputs 0; o_ready=1 from first cycle after reset release.
REQ-032 Reset mid-operation (READ or UPDATE) abandons the request: no memory write, no o_valid.
REQ-033 Memory contents are not reset; count=0 guarantees stale data is never subtracted.

Configuration
REQ-034 Macro SMA_MEAN_EN: when defined, adds output o_mean (DATA_WIDTH) = o_sum >> $clog2(BUFFER_SIZE) registered with o_valid, valid only when o_full, else 0.
REQ-035 Without SMA_MEAN_EN: port o_mean absent; all other behaviour identical.

Verification (NUM_STOCKS=2, BUFFER_SIZE=4, DATA_WIDTH=16)
REQ-036 Stock 0 prices 10,20,30,40 -> o_count 1..4, o_sum 10,30,60,100, o_full on 4th, o_outgoing_price 0 throughout.
REQ-037 Then stock 0 price 50 -> o_outgoing_price 10, o_sum 140, o_count 4; with SMA_MEAN_EN o_mean 35.
REQ-038 Stock 1 price 7 interleaved between stock 0 updates -> stock 1 o_sum 7, o_count 1; stock 0 sums unaffected.
REQ-039 i_valid held high continuously -> o_ready pattern 1,0,0 repeating, o_valid two cycles after each accept, no lost or duplicated update.
REQ-040 Stock 0 full, clear request -> o_sum 0, o_count 0; next price 5 -> o_sum 5, o_outgoing_price 0.
REQ-041 i_rst_n low during READ -> no o_valid, o_ready 1 after release, stock count 0.
